// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
//   DATA_W / ADDR_W / NREG : register file geometry (NREG == 2**ADDR_W)
//   req_e                  : requester identifiers, also used as the round-robin pointer value
//   reg_decode()           : one-hot register decode, qualified by an enable
package regfile_write_arbiter_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    function automatic logic [NREG-1:0] reg_decode(logic [ADDR_W-1:0] addr, logic en);
        return en ? (NREG'(1) << addr) : '0;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_slot.sv
// One-entry holding buffer for a single write port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture load_addr/load_data this edge (accepted handshake)
//   grant             : this slot issues this edge and frees unless reloaded
//   other_full        : the other slot currently holds a write
//   other_grant       : the other slot issues this edge
//   full, addr, data  : held write
//   age               : set when this write arrived behind a write still held in the other slot
module regfile_write_arbiter_slot
    import regfile_write_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              grant,
    input  logic              other_full,
    input  logic              other_grant,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              age
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
            age  <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            addr <= load_addr;
            data <= load_data;
            // Younger only if the other write stays held across this edge; a draining
            // and refilling other slot makes this a same-cycle tie instead.
            age  <= other_full && !other_grant;
        end else if (grant) begin
            full <= 1'b0;
            age  <= 1'b0;
        end else if (other_grant) begin
            // The older write is leaving, so this one becomes the oldest.
            age  <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between port A (ALU writeback) and
// port B (memory load data).
//   CLK, RESET                  : clock, asynchronous active-low reset
//   A_VALID/A_ADDR/A_DATA/A_READY : port A write handshake
//   B_VALID/B_ADDR/B_DATA/B_READY : port B write handshake
//   WRITE/INADDRESS/IN          : registered register-file write port
//   BUSY                        : per-register pending-write scoreboard
// Older held write issues first; same-cycle arrivals are broken by a round-robin
// pointer that moves to the loser after every contested grant.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_VALID,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_READY,
    input  logic              B_VALID,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              B_READY,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,
    output logic [NREG-1:0]   BUSY
);

    logic              full_a, full_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic              age_a, age_b;
    logic              grant_a, grant_b;
    logic              load_a, load_b;
    logic              pick_b;
    req_e              rr_q;

    // Grant depends only on registered slot state, so READY has no path from VALID.
    always_comb begin
        pick_b  = 1'b0;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (full_a && full_b) begin
            if (age_a != age_b) begin
                pick_b = age_a;
            end else begin
                pick_b = (rr_q == REQ_B);
            end
            grant_a = !pick_b;
            grant_b = pick_b;
        end else begin
            grant_a = full_a;
            grant_b = full_b;
        end
    end

    // RESET gates READY so nothing is offered while held in reset.
    assign A_READY = RESET && (!full_a || grant_a);
    assign B_READY = RESET && (!full_b || grant_b);
    assign load_a  = A_VALID && A_READY;
    assign load_b  = B_VALID && B_READY;

    regfile_write_arbiter_slot u_slot_a (
        .clk         (CLK),
        .rst_n       (RESET),
        .load        (load_a),
        .grant       (grant_a),
        .other_full  (full_b),
        .other_grant (grant_b),
        .load_addr   (A_ADDR),
        .load_data   (A_DATA),
        .full        (full_a),
        .addr        (addr_a),
        .data        (data_a),
        .age         (age_a)
    );

    regfile_write_arbiter_slot u_slot_b (
        .clk         (CLK),
        .rst_n       (RESET),
        .load        (load_b),
        .grant       (grant_b),
        .other_full  (full_a),
        .other_grant (grant_a),
        .load_addr   (B_ADDR),
        .load_data   (B_DATA),
        .full        (full_b),
        .addr        (addr_b),
        .data        (data_b),
        .age         (age_b)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
            rr_q      <= REQ_A;
        end else begin
            WRITE <= grant_a || grant_b;
            if (grant_a) begin
                INADDRESS <= addr_a;
                IN        <= data_a;
            end else if (grant_b) begin
                INADDRESS <= addr_b;
                IN        <= data_b;
            end
            if (full_a && full_b) begin
                rr_q <= grant_a ? REQ_B : REQ_A;
            end
        end
    end

    assign BUSY = reg_decode(addr_a, full_a)
                | reg_decode(addr_b, full_b)
                | reg_decode(INADDRESS, WRITE);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter, checked against a
// queue/timestamp reference model of the arbitration rules.
module tb_regfile_write_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       A_VALID = 1'b0, B_VALID = 1'b0;
    logic [2:0] A_ADDR = '0, B_ADDR = '0;
    logic [7:0] A_DATA = '0, B_DATA = '0;
    logic       A_READY, B_READY, WRITE;
    logic [2:0] INADDRESS;
    logic [7:0] IN;
    logic [7:0] BUSY;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    regfile_write_arbiter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .A_VALID   (A_VALID),
        .A_ADDR    (A_ADDR),
        .A_DATA    (A_DATA),
        .A_READY   (A_READY),
        .B_VALID   (B_VALID),
        .B_ADDR    (B_ADDR),
        .B_DATA    (B_DATA),
        .B_READY   (B_READY),
        .WRITE     (WRITE),
        .INADDRESS (INADDRESS),
        .IN        (IN),
        .BUSY      (BUSY)
    );

    // Register-file mirror and issue log fed from the DUT write port.
    logic [7:0] rf_dut [8] = '{default: 8'h00};
    logic [7:0] iss_q [$];
    always @(posedge CLK) begin
        if (WRITE) begin
            rf_dut[INADDRESS] <= IN;
            iss_q.push_back(IN);
        end
    end

    // Reference model: each port holds at most one write stamped with its accept cycle.
    bit         m_held [2];
    logic [2:0] m_addr [2];
    logic [7:0] m_data [2];
    int         m_stamp [2];
    int         m_rr;
    bit         m_write;
    logic [2:0] m_inaddr;
    logic [7:0] m_in;
    logic [7:0] m_rf [8];
    int         m_stores;
    int         cyc;
    bit         last_acc [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) m_held[p] = 1'b0;
        m_rr     = 0;
        m_write  = 1'b0;
        m_inaddr = '0;
        m_in     = '0;
    endtask

    function automatic int model_grant();
        if (m_held[0] && m_held[1]) begin
            if (m_stamp[0] < m_stamp[1]) return 0;
            if (m_stamp[1] < m_stamp[0]) return 1;
            return m_rr;
        end
        if (m_held[0]) return 0;
        if (m_held[1]) return 1;
        return -1;
    endfunction

    // Check outputs at the falling edge, drive inputs, advance the model over the next rise.
    task automatic drive_cycle(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                               input logic bv, input logic [2:0] ba, input logic [7:0] bd);
        int         g;
        bit         both;
        bit         rdy [2];
        logic [7:0] eb;
        @(negedge CLK);
        g       = model_grant();
        both    = m_held[0] && m_held[1];
        rdy[0]  = !m_held[0] || (g == 0);
        rdy[1]  = !m_held[1] || (g == 1);
        eb      = '0;
        for (int p = 0; p < 2; p++) if (m_held[p]) eb[m_addr[p]] = 1'b1;
        if (m_write) eb[m_inaddr] = 1'b1;
        check_eq("a_ready", A_READY, rdy[0]);
        check_eq("b_ready", B_READY, rdy[1]);
        check_eq("write", WRITE, m_write);
        check_eq("inaddress", INADDRESS, m_inaddr);
        check_eq("in", IN, m_in);
        check_eq("busy", BUSY, eb);
        A_VALID = av; A_ADDR = aa; A_DATA = ad;
        B_VALID = bv; B_ADDR = ba; B_DATA = bd;
        if (m_write) begin
            m_rf[m_inaddr] = m_in;
            m_stores++;
        end
        if (g >= 0) begin
            m_write   = 1'b1;
            m_inaddr  = m_addr[g];
            m_in      = m_data[g];
            m_held[g] = 1'b0;
            if (both) m_rr = 1 - g;
        end else begin
            m_write = 1'b0;
        end
        last_acc[0] = av && rdy[0];
        last_acc[1] = bv && rdy[1];
        if (last_acc[0]) begin
            m_held[0] = 1'b1; m_addr[0] = aa; m_data[0] = ad; m_stamp[0] = cyc;
        end
        if (last_acc[1]) begin
            m_held[1] = 1'b1; m_addr[1] = ba; m_data[1] = bd; m_stamp[1] = cyc;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        int n0, ia, ib, guard, za, zb, maxza, maxzb, na, nb;
        for (int r = 0; r < 8; r++) m_rf[r] = '0;
        m_stores = 0;
        cyc      = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_write", WRITE, 1'b0);
        check_eq("rst_inaddress", INADDRESS, 3'd0);
        check_eq("rst_in", IN, 8'h00);
        check_eq("rst_busy", BUSY, 8'h00);
        check_eq("rst_a_ready", A_READY, 1'b0);
        check_eq("rst_b_ready", B_READY, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;

        // Single write, latency and BUSY window
        drive_cycle(1'b1, 3'd3, 8'h5A, 1'b0, '0, '0);
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
        check_eq("single_busy_held", BUSY[3], 1'b1);
        check_eq("single_nowrite_yet", WRITE, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
        check_eq("single_write", WRITE, 1'b1);
        check_eq("single_addr", INADDRESS, 3'd3);
        check_eq("single_data", IN, 8'h5A);
        check_eq("single_busy_issue", BUSY[3], 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
        check_eq("single_write_drop", WRITE, 1'b0);
        check_eq("single_busy_clear", BUSY, 8'h00);

        // Same-cycle contention, twice: pointer starts at A then flips
        n0 = iss_q.size();
        drive_cycle(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
        idle(4);
        check_eq("cont1_count", iss_q.size() - n0, 2);
        check_eq("cont1_first", iss_q[n0], 8'h11);
        check_eq("cont1_second", iss_q[n0+1], 8'h22);
        n0 = iss_q.size();
        drive_cycle(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
        idle(4);
        check_eq("cont2_count", iss_q.size() - n0, 2);
        check_eq("cont2_first", iss_q[n0], 8'h22);
        check_eq("cont2_second", iss_q[n0+1], 8'h11);

        // Same-address ordering
        drive_cycle(1'b1, 3'd5, 8'hAA, 1'b0, '0, '0);
        drive_cycle(1'b0, '0, '0, 1'b1, 3'd5, 8'hBB);
        idle(4);
        check_eq("same_addr_r5", rf_dut[5], 8'hBB);

        // Both ports streaming 10 writes each
        n0 = iss_q.size();
        ia = 0; ib = 0; guard = 0; za = 0; zb = 0; maxza = 0; maxzb = 0;
        while ((ia < 10 || ib < 10) && guard < 60) begin
            drive_cycle(ia < 10, 3'(ia), 8'(8'hA0 + ia), ib < 10, 3'(ib + 4), 8'(8'hB0 + ib));
            if (ia < 10 && ib < 10 && cyc > 0) begin
                za = A_READY ? 0 : za + 1;
                zb = B_READY ? 0 : zb + 1;
                if (za > maxza) maxza = za;
                if (zb > maxzb) maxzb = zb;
            end
            if (last_acc[0]) ia++;
            if (last_acc[1]) ib++;
            guard++;
        end
        check_eq("stream_finished_in_budget", guard < 60, 1'b1);
        idle(4);
        check_eq("stream_count", iss_q.size() - n0, 20);
        check_eq("stream_a_ready_rate", maxza <= 1, 1'b1);
        check_eq("stream_b_ready_rate", maxzb <= 1, 1'b1);
        na = 0; nb = 0;
        for (int i = n0; i < iss_q.size(); i++) begin
            if (iss_q[i][7:4] == 4'hA) begin
                check_eq("stream_a_order", iss_q[i], 8'(8'hA0 + na));
                na++;
            end else begin
                check_eq("stream_b_order", iss_q[i], 8'(8'hB0 + nb));
                nb++;
            end
            if (i > n0) check_eq("stream_alternate", iss_q[i][7:4] != iss_q[i-1][7:4], 1'b1);
        end

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom_range(1, 0)), 3'($urandom), 8'($urandom),
                        1'($urandom_range(1, 0)), 3'($urandom), 8'($urandom));
        end

        // Reset mid-stream: held writes and a pending issue are discarded
        drive_cycle(1'b1, 3'd6, 8'hC6, 1'b1, 3'd7, 8'hD7);
        drive_cycle(1'b1, 3'd0, 8'hC0, 1'b1, 3'd1, 8'hD1);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        check_eq("midrst_write", WRITE, 1'b0);
        check_eq("midrst_busy", BUSY, 8'h00);
        check_eq("midrst_a_ready", A_READY, 1'b0);
        check_eq("midrst_b_ready", B_READY, 1'b0);
        @(posedge CLK);
        #1;
        check_eq("midrst_no_issue", WRITE, 1'b0);
        check_eq("midrst_busy_hold", BUSY, 8'h00);
        @(negedge CLK);
        A_VALID = 1'b0;
        B_VALID = 1'b0;
        RESET   = 1'b1;
        idle(3);
        drive_cycle(1'b1, 3'd2, 8'h42, 1'b0, '0, '0);
        idle(4);

        @(posedge CLK);
        #1;
        check_eq("store_count", iss_q.size(), m_stores);
        for (int r = 0; r < 8; r++) check_eq("final_rf", rf_dut[r], m_rf[r]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
